// File: rtl/mdu_pkg.sv
// Shared encodings and decode helpers for the iterative multiply/divide unit.
// Pure constants and functions: no latency, no flow control.
package mdu_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_e;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // MUL low half is sign-agnostic; treating it as signed keeps one fix-up path.
    function automatic logic is_signed_lhs(input logic [2:0] f3);
        return (f3 == OP_MUL) || (f3 == OP_MULH) || (f3 == OP_MULHSU) ||
               (f3 == OP_DIV) || (f3 == OP_REM);
    endfunction

    function automatic logic is_signed_rhs(input logic [2:0] f3);
        return (f3 == OP_MUL) || (f3 == OP_MULH) ||
               (f3 == OP_DIV) || (f3 == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// Radix-2 shift-add / restoring shift-subtract engine on unsigned magnitudes.
// One iteration per step_i; acc_nxt_o is the combinational result of the current step.
// No backpressure of its own: the owner gates step_i.
module mdu_shift_core #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              mode_div_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_nxt_o,
    output logic              last_iter_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mode_q, mode_d;

    logic [XLEN-1:0]   hi, lo;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     shifted;
    logic [XLEN+1:0]   diff;
    logic [2*XLEN-1:0] mul_nxt, div_nxt;

    assign hi = acc_q[2*XLEN-1:XLEN];
    assign lo = acc_q[XLEN-1:0];

    // hi stays below the divisor, so the trial difference never exceeds XLEN+2 bits.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        mul_nxt = {sum, lo[XLEN-1:1]};
        shifted = {hi, lo[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, b_q};
        div_nxt = diff[XLEN+1] ? {shifted[XLEN-1:0], lo[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0],    lo[XLEN-2:0], 1'b1};
    end

    assign acc_nxt_o   = mode_q ? div_nxt : mul_nxt;
    assign last_iter_o = (cnt_q == CNT_W'(XLEN-1));

    always_comb begin
        acc_d  = acc_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (load_i) begin
            acc_d  = {{XLEN{1'b0}}, a_i};
            b_d    = b_i;
            cnt_d  = '0;
            mode_d = mode_div_i;
        end else if (step_i) begin
            acc_d  = acc_nxt_o;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle RV M-extension multiply/divide unit holding one operation at a time.
// Latency XLEN+1 cycles (1 for divide-by-zero / signed overflow); result is a 1-cycle ready pulse.
// busy blocks issue while iterating; rdy_in low freezes everything, clear aborts.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 calc_enable,
    input  logic                 clear,
    input  logic [XLEN-1:0]      lhs,
    input  logic [XLEN-1:0]      rhs,
    input  logic [2:0]           op,
    input  logic [ROB_WIDTH-1:0] rob_dep,
    output logic                 busy,
    output logic                 ready,
    output logic [ROB_WIDTH-1:0] rob_id,
    output logic [XLEN-1:0]      value
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e                 state_q;
    logic [2:0]             op_q;
    logic [ROB_WIDTH-1:0]   tag_q;
    logic                   sl_q, sr_q;
    logic                   ready_q;
    logic [XLEN-1:0]        value_q;
    logic [ROB_WIDTH-1:0]   rob_id_q;

    logic                   sl, sr, div_zero, ovf, fast;
    logic [XLEN-1:0]        mag_l, mag_r, fast_val;
    logic                   core_load, core_step, last_iter;
    logic [2*XLEN-1:0]      acc_nxt, prod;
    logic [XLEN-1:0]        quo, rem, fin_val;

    always_comb begin
        sl       = is_signed_lhs(op) & lhs[XLEN-1];
        sr       = is_signed_rhs(op) & rhs[XLEN-1];
        mag_l    = sl ? (XLEN'(0) - lhs) : lhs;
        mag_r    = sr ? (XLEN'(0) - rhs) : rhs;
        div_zero = is_div(op) && (rhs == '0);
        ovf      = ((op == OP_DIV) || (op == OP_REM)) && (lhs == XMIN) && (rhs == '1);
        fast     = div_zero || ovf;
        if (div_zero)
            fast_val = op[1] ? lhs : '1;
        else
            fast_val = op[1] ? '0 : XMIN;
    end

    assign core_load = rdy_in && !clear && (state_q == ST_IDLE) && calc_enable && !fast;
    assign core_step = rdy_in && !clear && (state_q == ST_CALC);

    mdu_shift_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .load_i      (core_load),
        .step_i      (core_step),
        .mode_div_i  (is_div(op)),
        .a_i         (mag_l),
        .b_i         (mag_r),
        .acc_nxt_o   (acc_nxt),
        .last_iter_o (last_iter)
    );

    // Sign fix-up on the final step's combinational result.
    always_comb begin
        prod = (sl_q ^ sr_q) ? ((2*XLEN)'(0) - acc_nxt) : acc_nxt;
        quo  = acc_nxt[XLEN-1:0];
        rem  = acc_nxt[2*XLEN-1:XLEN];
        if (sl_q ^ sr_q)
            quo = XLEN'(0) - quo;
        if (sl_q)
            rem = XLEN'(0) - rem;
        if (is_div(op_q))
            fin_val = op_q[1] ? rem : quo;
        else
            fin_val = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            tag_q    <= '0;
            sl_q     <= 1'b0;
            sr_q     <= 1'b0;
            ready_q  <= 1'b0;
            value_q  <= '0;
            rob_id_q <= '0;
        end else if (rdy_in && clear) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            value_q  <= '0;
            rob_id_q <= '0;
        end else if (!rdy_in) begin
            ready_q  <= 1'b0;
            value_q  <= '0;
            rob_id_q <= '0;
        end else begin
            ready_q  <= 1'b0;
            value_q  <= '0;
            rob_id_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (calc_enable) begin
                        op_q  <= op;
                        tag_q <= rob_dep;
                        sl_q  <= sl;
                        sr_q  <= sr;
                        if (fast) begin
                            ready_q  <= 1'b1;
                            value_q  <= fast_val;
                            rob_id_q <= rob_dep;
                        end else begin
                            state_q  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (last_iter) begin
                        ready_q  <= 1'b1;
                        value_q  <= fin_val;
                        rob_id_q <= tag_q;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (state_q == ST_CALC);
    assign ready  = ready_q;
    assign value  = value_q;
    assign rob_id = rob_id_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: multiply, divide, fast paths, flush, stall, protocol and reset.
module tb_mdu_iter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, calc_enable, clear;
    logic [31:0] lhs, rhs;
    logic [2:0]  op;
    logic [3:0]  rob_dep;
    logic        busy, ready;
    logic [3:0]  rob_id;
    logic [31:0] value;

    int vectors = 0;
    int errors  = 0;

    always #5 clk_in = ~clk_in;

    mdu_iter #(.XLEN(32), .ROB_WIDTH(4)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .calc_enable (calc_enable),
        .clear       (clear),
        .lhs         (lhs),
        .rhs         (rhs),
        .op          (op),
        .rob_dep     (rob_dep),
        .busy        (busy),
        .ready       (ready),
        .rob_id      (rob_id),
        .value       (value)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t);
        op = o; lhs = a; rhs = b; rob_dep = t; calc_enable = 1'b1;
        tick();
        calc_enable = 1'b0;
    endtask

    // Latency counted from the accept cycle; bounded so a dead DUT cannot hang the run.
    task automatic wait_ready(output int lat);
        lat = 1;
        while (!ready && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) tick();
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b exp=0", ready); end
        vectors++; if (value !== 32'h0) begin errors++; $display("FAIL reset_value got=%h exp=0", value); end
        vectors++; if (rob_id !== 4'h0) begin errors++; $display("FAIL reset_rob_id got=%h exp=0", rob_id); end
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 4'd3);
        wait_ready(lat);
        vectors++; if (lat != 33) begin errors++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        vectors++; if (value !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_value got=%h exp=ffffffeb", value); end
        vectors++; if (rob_id !== 4'd3) begin errors++; $display("FAIL mul_rob_id got=%0d exp=3", rob_id); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL ready_cycle_busy got=%0b exp=0", busy); end
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd12);
        wait_ready(lat);
        vectors++; if (lat != 33) begin errors++; $display("FAIL mulhu_latency got=%0d exp=33", lat); end
        vectors++; if (value !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_value got=%h exp=fffffffe", value); end
        vectors++; if (rob_id !== 4'd12) begin errors++; $display("FAIL mulhu_rob_id got=%0d exp=12", rob_id); end
        tick();
        vectors++; if (ready !== 1'b0 || value !== 32'h0 || rob_id !== 4'h0)
            begin errors++; $display("FAIL post_pulse_idle got ready=%0b value=%h rob_id=%h exp 0/0/0", ready, value, rob_id); end
    endtask

    task automatic test_iterative_table();
        logic [2:0]  ops [9] = '{3'b100, 3'b110, 3'b101, 3'b100, 3'b110, 3'b111, 3'b010, 3'b001, 3'b011};
        logic [31:0] as  [9] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'h8000_0000, 32'd20, 32'd20,
                                 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [9] = '{32'd3, 32'd3, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
                                 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] exp [9] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFA, 32'd2,
                                 32'd2, 32'hFFFF_FFFF, 32'h0, 32'h1};
        int lat;
        for (int i = 0; i < 9; i++) begin
            issue(ops[i], as[i], bs[i], 4'(i + 1));
            wait_ready(lat);
            vectors++; if (lat != 33 || value !== exp[i] || rob_id !== 4'(i + 1))
                begin errors++; $display("FAIL iter_op%0d got lat=%0d value=%h rob_id=%0d exp lat=33 value=%h rob_id=%0d",
                                         i, lat, value, rob_id, exp[i], i + 1); end
            tick();
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]  ops [6] = '{3'b100, 3'b111, 3'b100, 3'b110, 3'b101, 3'b110};
        logic [31:0] as  [6] = '{32'd5, 32'd9, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd7};
        logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'd9, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd7};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], 4'(8 + i));
            vectors++; if (ready !== 1'b1 || busy !== 1'b0 || value !== exp[i] || rob_id !== 4'(8 + i))
                begin errors++; $display("FAIL fast_op%0d got ready=%0b busy=%0b value=%h rob_id=%0d exp 1/0/%h/%0d",
                                         i, ready, busy, value, rob_id, exp[i], 8 + i); end
            tick();
        end
    endtask

    task automatic test_flush();
        logic seen;
        issue(3'b100, 32'd1000, 32'd7, 4'd6);
        repeat (10) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++; if (busy !== 1'b0 || ready !== 1'b0)
            begin errors++; $display("FAIL flush_idle got busy=%0b ready=%0b exp 0/0", busy, ready); end
        seen = 1'b0;
        repeat (40) begin tick(); if (ready) seen = 1'b1; end
        vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_ready got=%0b exp=0", seen); end
        op = 3'b000; lhs = 32'd2; rhs = 32'd3; rob_dep = 4'd7;
        calc_enable = 1'b1; clear = 1'b1;
        tick();
        calc_enable = 1'b0; clear = 1'b0;
        seen = busy | ready;
        repeat (40) begin tick(); if (ready || busy) seen = 1'b1; end
        vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL clear_drops_issue got=%0b exp=0", seen); end
    endtask

    task automatic test_stall();
        int  lat;
        logic seen;
        issue(3'b001, 32'hFFFF_FFFE, 32'd3, 4'd9);
        lat = 1;
        repeat (10) begin tick(); lat++; end
        rdy_in = 1'b0;
        seen = 1'b0;
        repeat (5) begin tick(); lat++; if (ready) seen = 1'b1; end
        rdy_in = 1'b1;
        vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL stall_ready got=%0b exp=0", seen); end
        while (!ready && lat < 200) begin tick(); lat++; end
        vectors++; if (lat != 38) begin errors++; $display("FAIL stall_latency got=%0d exp=38", lat); end
        vectors++; if (value !== 32'hFFFF_FFFF || rob_id !== 4'd9)
            begin errors++; $display("FAIL stall_result got value=%h rob_id=%0d exp ffffffff/9", value, rob_id); end
        tick();
    endtask

    task automatic test_protocol();
        int lat;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 4'd5);
        lat = 1;
        repeat (5) begin tick(); lat++; end
        op = 3'b100; lhs = 32'd100; rhs = 32'd0; rob_dep = 4'd14; calc_enable = 1'b1;
        tick(); lat++;
        calc_enable = 1'b0;
        while (!ready && lat < 200) begin tick(); lat++; end
        vectors++; if (lat != 33 || value !== 32'hFFFF_FFEB || rob_id !== 4'd5)
            begin errors++; $display("FAIL busy_issue_ignored got lat=%0d value=%h rob_id=%0d exp 33/ffffffeb/5",
                                     lat, value, rob_id); end
        tick();
    endtask

    task automatic test_reset_mid_calc();
        logic seen;
        issue(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 4'd11);
        repeat (7) tick();
        rst_in = 1'b1;
        tick();
        vectors++; if (busy !== 1'b0 || ready !== 1'b0 || value !== 32'h0 || rob_id !== 4'h0)
            begin errors++; $display("FAIL reset_mid_calc got busy=%0b ready=%0b value=%h rob_id=%h exp all 0",
                                     busy, ready, value, rob_id); end
        rst_in = 1'b0;
        seen = 1'b0;
        repeat (40) begin tick(); if (ready || busy) seen = 1'b1; end
        vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_ready got=%0b exp=0", seen); end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; calc_enable = 1'b0; clear = 1'b0;
        lhs = '0; rhs = '0; op = '0; rob_dep = '0;
        test_reset();
        test_back_to_back();
        test_iterative_table();
        test_fast_path();
        test_flush();
        test_stall();
        test_protocol();
        test_reset_mid_calc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
